// File: rtl/gate_response_checker.sv
// Checks a 2-input gate under test: samples {in_1,in_2} once per stable input interval,
// compares out_1 against the expected gate function and counts mismatches over a run.
module gate_response_checker #(
    parameter int FUNC        = 0,
    parameter int SETTLE      = 2,
    parameter int NUM_VECTORS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       out_1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sample_cnt,
    output logic [7:0] err_cnt,
    output logic [1:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] FUNC_C      = 3'(FUNC);
    localparam logic [3:0] SETTLE_C    = 4'(SETTLE);
    localparam logic [3:0] SETTLE_M1   = 4'(SETTLE - 1);
    localparam logic [7:0] NUM_VEC_C   = 8'(NUM_VECTORS);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_prev;
    logic [3:0] r_stab_cnt;
    logic [7:0] r_sample_cnt;
    logic [7:0] r_err_cnt;
    logic [1:0] r_first_err_vec;
    logic       r_first_err_valid;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic [1:0] w_vec;
    logic       w_changed;
    logic       w_expected;
    logic       w_sample;
    logic       w_mismatch;
    logic       w_last_sample;
    logic       w_start_run;
    logic [7:0] w_sample_inc;

    logic [1:0] w_prev_next;
    logic [3:0] w_stab_cnt_next;
    logic [7:0] w_sample_cnt_next;
    logic [7:0] w_err_cnt_next;
    logic [1:0] w_first_err_vec_next;
    logic       w_first_err_valid_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic       w_pass_next;

    assign w_vec        = {in_1, in_2};
    assign w_changed    = (w_vec != r_prev);
    assign w_sample_inc = r_sample_cnt + 8'd1;
    assign w_start_run  = start && (r_state != RUN);

    // Reference gate model; unused codes fall back to AND.
    always_comb begin
        w_expected = in_1 & in_2;
        case (FUNC_C)
            3'd1:    w_expected = in_1 | in_2;
            3'd2:    w_expected = in_1 ^ in_2;
            3'd3:    w_expected = ~(in_1 & in_2);
            3'd4:    w_expected = ~(in_1 | in_2);
            3'd5:    w_expected = ~(in_1 ^ in_2);
            default: w_expected = in_1 & in_2;
        endcase
    end

    // A sample fires once, on the cycle the input has been stable for SETTLE edges.
    assign w_sample      = (r_state == RUN) && !w_changed && (r_stab_cnt == SETTLE_M1);
    assign w_mismatch    = w_sample && (out_1 != w_expected);
    assign w_last_sample = w_sample && (w_sample_inc == NUM_VEC_C);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last_sample) w_state_next = DONE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode, registered so busy/done/pass line up with the state register
    always_comb begin
        w_busy_next = (w_state_next == RUN);
        w_done_next = (w_state_next == DONE);
        w_pass_next = (w_state_next == DONE) && (w_err_cnt_next == 8'd0);
    end

    // Datapath next-values
    always_comb begin
        w_prev_next            = r_prev;
        w_stab_cnt_next        = r_stab_cnt;
        w_sample_cnt_next      = r_sample_cnt;
        w_err_cnt_next         = r_err_cnt;
        w_first_err_vec_next   = r_first_err_vec;
        w_first_err_valid_next = r_first_err_valid;
        if (w_start_run) begin
            w_prev_next            = w_vec;
            w_stab_cnt_next        = 4'd0;
            w_sample_cnt_next      = 8'd0;
            w_err_cnt_next         = 8'd0;
            w_first_err_vec_next   = 2'b00;
            w_first_err_valid_next = 1'b0;
        end else if (r_state == RUN) begin
            w_prev_next = w_vec;
            if (w_changed) begin
                w_stab_cnt_next = 4'd0;
            end else if (r_stab_cnt < SETTLE_C) begin
                w_stab_cnt_next = r_stab_cnt + 4'd1;
            end
            if (w_sample) begin
                w_sample_cnt_next = w_sample_inc;
            end
            if (w_mismatch) begin
                if (r_err_cnt != 8'hFF) begin
                    w_err_cnt_next = r_err_cnt + 8'd1;
                end
                if (!r_first_err_valid) begin
                    w_first_err_vec_next   = w_vec;
                    w_first_err_valid_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev            <= 2'b00;
            r_stab_cnt        <= 4'd0;
            r_sample_cnt      <= 8'd0;
            r_err_cnt         <= 8'd0;
            r_first_err_vec   <= 2'b00;
            r_first_err_valid <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
        end else begin
            r_prev            <= w_prev_next;
            r_stab_cnt        <= w_stab_cnt_next;
            r_sample_cnt      <= w_sample_cnt_next;
            r_err_cnt         <= w_err_cnt_next;
            r_first_err_vec   <= w_first_err_vec_next;
            r_first_err_valid <= w_first_err_valid_next;
            r_busy            <= w_busy_next;
            r_done            <= w_done_next;
            r_pass            <= w_pass_next;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign sample_cnt      = r_sample_cnt;
    assign err_cnt         = r_err_cnt;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench: an AND checker and an XOR checker share stimulus; runs come from a
// vector table, multi-cycle corner cases are hand-sequenced.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic reset, start, in_1, in_2, stuck;
    logic out_and, out_xor;

    logic       a_busy, a_done, a_pass, a_fevalid;
    logic [7:0] a_sc, a_ec;
    logic [1:0] a_fev;
    logic       x_busy, x_done, x_pass, x_fevalid;
    logic [7:0] x_sc, x_ec;
    logic [1:0] x_fev;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // AND checker sees a correct AND (or a stuck-at-1 output); XOR checker always sees AND.
    assign out_and = stuck ? 1'b1 : (in_1 & in_2);
    assign out_xor = in_1 & in_2;

    gate_response_checker #(.FUNC(0), .SETTLE(2), .NUM_VECTORS(4)) u_dut_and (
        .clk(clk), .reset(reset), .start(start), .in_1(in_1), .in_2(in_2), .out_1(out_and),
        .busy(a_busy), .done(a_done), .pass(a_pass), .sample_cnt(a_sc), .err_cnt(a_ec),
        .first_err_vec(a_fev), .first_err_valid(a_fevalid)
    );

    gate_response_checker #(.FUNC(2), .SETTLE(2), .NUM_VECTORS(4)) u_dut_xor (
        .clk(clk), .reset(reset), .start(start), .in_1(in_1), .in_2(in_2), .out_1(out_xor),
        .busy(x_busy), .done(x_done), .pass(x_pass), .sample_cnt(x_sc), .err_cnt(x_ec),
        .first_err_vec(x_fev), .first_err_valid(x_fevalid)
    );

    typedef struct {
        bit         sel_xor;
        bit         stuck;
        logic [7:0] vecs;     // vector k in bits [7-2k -: 2]
        logic       exp_pass;
        logic [7:0] exp_sc;
        logic [7:0] exp_ec;
        logic [1:0] exp_fev;
        logic       exp_fevalid;
    } run_t;

    run_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_vec(input logic [1:0] v);
        in_1 = v[1];
        in_2 = v[0];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_and_all(input string tag, input int bsy, input int dn, input int ps,
                                 input int sc, input int ec, input int fev, input int fv);
        check({tag, "_busy"}, a_busy, bsy);
        check({tag, "_done"}, a_done, dn);
        check({tag, "_pass"}, a_pass, ps);
        check({tag, "_sample_cnt"}, a_sc, sc);
        check({tag, "_err_cnt"}, a_ec, ec);
        check({tag, "_first_err_vec"}, a_fev, fev);
        check({tag, "_first_err_valid"}, a_fevalid, fv);
    endtask

    initial begin
        logic [7:0] vv;
        logic [1:0] v;
        string      tag;

        //            sel   stuck vecs          pass  sc    ec    fev    fevalid
        tbl[0] = '{1'b0, 1'b0, 8'b00_01_11_10, 1'b1, 8'd4, 8'd0, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'b00_01_11_10, 1'b0, 8'd4, 8'd3, 2'b00, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'b00_01_11_00, 1'b0, 8'd4, 8'd2, 2'b01, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'b01_10_01_10, 1'b0, 8'd4, 8'd4, 2'b01, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'b11_00_11_00, 1'b0, 8'd4, 8'd2, 2'b00, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'b10_11_01_11, 1'b1, 8'd4, 8'd0, 2'b00, 1'b0};

        reset = 1'b1; start = 1'b0; stuck = 1'b0;
        set_vec(2'b00);
        step(3);
        reset = 1'b0;
        step(1);
        check_and_all("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset_xor_busy", x_busy, 0);

        // Table runs: each vector held 20 cycles, checked once DONE has been reached
        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("run%0d", i);
            vv = tbl[i].vecs;
            stuck = tbl[i].stuck;
            set_vec(vv[7:6]);
            pulse_start();
            check({tag, "_busy_after_start"}, tbl[i].sel_xor ? x_busy : a_busy, 1);
            check({tag, "_cnt_cleared"}, tbl[i].sel_xor ? x_sc : a_sc, 0);
            for (int k = 0; k < 4; k++) begin
                v = vv[7-2*k -: 2];
                set_vec(v);
                step(20);
            end
            if (tbl[i].sel_xor) begin
                check({tag, "_done"}, x_done, 1);
                check({tag, "_busy"}, x_busy, 0);
                check({tag, "_pass"}, x_pass, tbl[i].exp_pass);
                check({tag, "_sample_cnt"}, x_sc, tbl[i].exp_sc);
                check({tag, "_err_cnt"}, x_ec, tbl[i].exp_ec);
                check({tag, "_first_err_vec"}, x_fev, tbl[i].exp_fev);
                check({tag, "_first_err_valid"}, x_fevalid, tbl[i].exp_fevalid);
            end else begin
                check_and_all(tag, 0, 1, tbl[i].exp_pass, tbl[i].exp_sc, tbl[i].exp_ec,
                              tbl[i].exp_fev, tbl[i].exp_fevalid);
            end
        end

        // Inputs changing every cycle never settle: no samples, RUN persists
        stuck = 1'b0;
        set_vec(2'b00);
        pulse_start();
        for (int j = 0; j < 50; j++) begin
            set_vec((j % 2 == 0) ? 2'b11 : 2'b00);
            step(1);
        end
        check("toggle_busy", a_busy, 1);
        check("toggle_done", a_done, 0);
        check("toggle_sample_cnt", a_sc, 0);

        // Held vector: one sample, two edges after the change
        stuck = 1'b1;
        set_vec(2'b01);
        step(1);
        check("settle_edge0", a_sc, 0);
        step(1);
        check("settle_edge1", a_sc, 0);
        step(1);
        check("settle_edge2", a_sc, 1);
        step(10);
        check("settle_single", a_sc, 1);
        check("settle_err", a_ec, 1);
        check("settle_fev", a_fev, 1);
        check("settle_fevalid", a_fevalid, 1);

        // Change on the would-be sample cycle suppresses it
        set_vec(2'b10);
        step(2);
        set_vec(2'b11);
        step(1);
        check("suppress_cnt", a_sc, 1);
        step(2);
        check("second_sample", a_sc, 2);
        check("second_err", a_ec, 1);

        // start is ignored while running
        pulse_start();
        check("start_in_run_cnt", a_sc, 2);
        check("start_in_run_err", a_ec, 1);
        check("start_in_run_busy", a_busy, 1);

        // Reset mid-run clears everything on the next edge
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_and_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        step(3);
        check("idle_hold_busy", a_busy, 0);
        check("idle_hold_cnt", a_sc, 0);

        // Clean run after reset
        stuck = 1'b0;
        set_vec(2'b00);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            v = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b11 : 2'b10;
            set_vec(v);
            step(20);
        end
        check_and_all("clean", 0, 1, 1, 4, 0, 0, 0);

        // DONE holds, then start restarts
        step(5);
        check("done_hold", a_done, 1);
        pulse_start();
        check("restart_busy", a_busy, 1);
        check("restart_done", a_done, 0);
        check("restart_pass", a_pass, 0);
        check("restart_cnt", a_sc, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
